// File: rtl/tuner_iq_nco_if.sv
// Sample, control and I/Q result bundle for the quadrature tuner.
interface tuner_iq_nco_if #(
  parameter int dsz = 14,
  parameter int psz = 26,
  parameter int lsz = 10
) ();
  logic signed [dsz-1:0] in;
  logic                  in_valid;
  logic [psz-1:0]        freq;
  logic                  freq_ld;
  logic [lsz+1:0]        phs_ofs;
  logic                  phs_clr;
  logic [1:0]            mode;
  logic signed [dsz-1:0] out_i;
  logic signed [dsz-1:0] out_q;
  logic                  out_valid;

  modport master (
    output in, in_valid, freq, freq_ld, phs_ofs, phs_clr, mode,
    input  out_i, out_q, out_valid
  );

  modport slave (
    input  in, in_valid, freq, freq_ld, phs_ofs, phs_clr, mode,
    output out_i, out_q, out_valid
  );
endinterface

// File: rtl/tuner_iq_nco.sv
// Real-to-complex quadrature tuner: phase accumulator, shared quarter-wave
// sine LUT with two read ports, signed mix, round and saturate.
// Eight register ranks: a sample captured at edge N is on the outputs after N+7.
module tuner_iq_nco #(
  parameter int dsz = 14,
  parameter int psz = 26,
  parameter int lsz = 10
) (
  input  logic          clk,
  input  logic          reset,
  tuner_iq_nco_if.slave bus
);
  localparam int PW     = lsz + 2;
  localparam int LD     = 2 ** lsz;
  localparam int MW     = dsz + 16;
  localparam int STAGES = 7;
  localparam logic signed [dsz-1:0] SMAX = {1'b0, {(dsz-1){1'b1}}};
  localparam logic signed [dsz-1:0] SMIN = {1'b1, {(dsz-1){1'b0}}};

  // Quarter-wave entry k = round(32767*sin((2k+1)*pi/2^(lsz+2))), Taylor series.
  function automatic int lut_val(int k);
    real x, term, sum;
    x    = real'(2 * k + 1) * 3.14159265358979323846 / real'(2 ** (lsz + 2));
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(32767.0 * sum + 0.5);
  endfunction

  logic signed [15:0] lut [LD];
  for (genvar k = 0; k < LD; k++) begin : g_lut
    assign lut[k] = 16'(lut_val(k));
  end

  function automatic logic signed [dsz-1:0] sat(logic signed [dsz:0] r);
    if (r[dsz] != r[dsz-1]) return r[dsz] ? SMIN : SMAX;
    return r[dsz-1:0];
  endfunction

  logic [psz-1:0]        inc_q, inc_d, acc_q, acc_d;
  logic [STAGES:0]       vld_pipe;
  // stage 1: captured sample, mode, phase
  logic signed [dsz-1:0] in1_q;
  logic [1:0]            md1_q;
  logic [PW-1:0]         p1_q;
  // stage 2: LUT addresses and result signs
  logic signed [dsz-1:0] in2_q;
  logic [1:0]            md2_q;
  logic [lsz-1:0]        as2_q, ac2_q;
  logic                  ns2_q, nc2_q;
  // stage 3: raw table values
  logic signed [dsz-1:0] in3_q;
  logic [1:0]            md3_q;
  logic signed [15:0]    ts3_q, tc3_q;
  logic                  ns3_q, nc3_q;
  // stage 4..7 and output
  logic signed [dsz-1:0] s4_q;
  logic                  byp4_q;
  logic signed [15:0]    ti4_q, tq4_q;
  logic signed [MW-1:0]  mi5_q, mq5_q;
  logic signed [dsz:0]   ri6_q, rq6_q;
  logic signed [dsz-1:0] si7_q, sq7_q, oi_q, oq_q;

  logic [1:0]         qs, qc;
  logic signed [15:0] sin_t, cos_t, tq_d;

  // Increment load and accumulator update; clear overrides advance.
  always_comb begin
    inc_d = bus.freq_ld ? bus.freq : inc_q;
    acc_d = acc_q;
    if (bus.phs_clr)       acc_d = '0;
    else if (bus.in_valid) acc_d = acc_q + inc_q;
  end

  // Quadrant decode for sine (qs) and cosine (qc = qs+1).
  always_comb begin
    qs = p1_q[lsz+1:lsz];
    qc = qs + 2'd1;
  end

  // Sign application; down-mix negates the sine leg before the multiply.
  always_comb begin
    sin_t = ns3_q ? -ts3_q : ts3_q;
    cos_t = nc3_q ? -tc3_q : tc3_q;
    tq_d  = (md3_q == 2'b00) ? -sin_t : sin_t;
  end

  // Phase accumulator, increment register and valid shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q    <= '0;
      acc_q    <= '0;
      vld_pipe <= '0;
    end else begin
      inc_q    <= inc_d;
      acc_q    <= acc_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
    end
  end

  // Front stages: capture with pre-update phase, address fold, LUT read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in1_q <= '0; md1_q <= '0; p1_q  <= '0;
      in2_q <= '0; md2_q <= '0; as2_q <= '0; ac2_q <= '0; ns2_q <= 1'b0; nc2_q <= 1'b0;
      in3_q <= '0; md3_q <= '0; ts3_q <= '0; tc3_q <= '0; ns3_q <= 1'b0; nc3_q <= 1'b0;
    end else begin
      in1_q <= bus.in;
      md1_q <= bus.mode;
      p1_q  <= acc_q[psz-1 -: PW] + bus.phs_ofs;
      in2_q <= in1_q;
      md2_q <= md1_q;
      as2_q <= p1_q[lsz-1:0] ^ {lsz{qs[0]}};
      ac2_q <= p1_q[lsz-1:0] ^ {lsz{qc[0]}};
      ns2_q <= qs[1];
      nc2_q <= qc[1];
      in3_q <= in2_q;
      md3_q <= md2_q;
      ts3_q <= lut[as2_q];
      tc3_q <= lut[ac2_q];
      ns3_q <= ns2_q;
      nc3_q <= nc2_q;
    end
  end

  // Back stages: sign/source select, multiply, round, saturate, hold output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s4_q  <= '0; byp4_q <= 1'b0; ti4_q <= '0; tq4_q <= '0;
      mi5_q <= '0; mq5_q  <= '0;
      ri6_q <= '0; rq6_q  <= '0;
      si7_q <= '0; sq7_q  <= '0;
      oi_q  <= '0; oq_q   <= '0;
    end else begin
      s4_q   <= (md3_q == 2'b11) ? SMAX : in3_q;
      byp4_q <= (md3_q == 2'b10);
      ti4_q  <= cos_t;
      tq4_q  <= tq_d;
      // Bypass is scaled by 2^15 so the shared rounder returns the sample exactly.
      mi5_q  <= byp4_q ? (MW'(s4_q) <<< 15) : (MW'(s4_q) * MW'(ti4_q));
      mq5_q  <= byp4_q ? '0 : (MW'(s4_q) * MW'(tq4_q));
      ri6_q  <= (dsz+1)'((mi5_q + MW'(2 ** 14)) >>> 15);
      rq6_q  <= (dsz+1)'((mq5_q + MW'(2 ** 14)) >>> 15);
      si7_q  <= sat(ri6_q);
      sq7_q  <= sat(rq6_q);
      if (vld_pipe[STAGES-1]) begin
        oi_q <= si7_q;
        oq_q <= sq7_q;
      end
    end
  end

  assign bus.out_i     = oi_q;
  assign bus.out_q     = oq_q;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_tuner_iq_nco.sv
// Directed bench for tuner_iq_nco with a reference model feeding a scoreboard.
module tb_tuner_iq_nco;
  localparam int DSZ = 14, PSZ = 26, LSZ = 10;
  localparam int L = 1 << LSZ;
  localparam real PI = 3.14159265358979323846;

  typedef struct { int i; int q; } iq_t;

  logic clk = 1'b0, rst_n = 1'b0;
  int   n_vec = 0, n_err = 0;
  iq_t  sb[$];
  longint acc_m = 0, inc_m = 0;
  logic [7:0] vh = '0;

  tuner_iq_nco_if #(.dsz(DSZ), .psz(PSZ), .lsz(LSZ)) bus ();
  tuner_iq_nco #(.dsz(DSZ), .psz(PSZ), .lsz(LSZ)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tbl(int k);
    return int'($floor(32767.0 * $sin((2.0 * k + 1.0) * PI / real'(4 * L)) + 0.5));
  endfunction

  function automatic int trig(int p);
    int q, a, v;
    q = (p >> LSZ) & 3;
    a = p & (L - 1);
    if (q & 1) a = L - 1 - a;
    v = tbl(a);
    return (q & 2) ? -v : v;
  endfunction

  function automatic int mix(int s, int t);
    longint m, r;
    m = longint'(s) * longint'(t);
    r = (m + 16384) >>> 15;
    if (r > 8191) r = 8191;
    if (r < -8192) r = -8192;
    return int'(r);
  endfunction

  function automatic iq_t model(int smp, int md, int p);
    iq_t e;
    int s, sn, cs;
    s  = (md == 3) ? 8191 : smp;
    sn = trig(p);
    cs = trig((p + L) & (4 * L - 1));
    e.i = mix(s, cs);
    e.q = (md == 0) ? mix(s, -sn) : mix(s, sn);
    if (md == 2) begin e.i = smp; e.q = 0; end
    return e;
  endfunction

  // One clock: model update at the edge, then check outputs 1 time unit later.
  task automatic tick();
    iq_t e;
    int p;
    @(posedge clk);
    if (!rst_n) begin
      acc_m = 0; inc_m = 0; vh = '0;
    end else begin
      if (bus.in_valid) begin
        p = int'(((acc_m >> (PSZ - LSZ - 2)) + longint'(bus.phs_ofs)) & (4 * L - 1));
        sb.push_back(model(int'(bus.in), int'(bus.mode), p));
      end
      if (bus.phs_clr)       acc_m = 0;
      else if (bus.in_valid) acc_m = (acc_m + inc_m) & ((64'd1 << PSZ) - 1);
      if (bus.freq_ld) inc_m = longint'(bus.freq);
      vh = {vh[6:0], bus.in_valid};
    end
    #1;
    chk("out_valid", bus.out_valid, vh[7]);
    if (bus.out_valid) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_i", bus.out_i, e.i);
        chk("out_q", bus.out_q, e.q);
      end
    end
  endtask

  task automatic drive(input int smp, input int vld, input int md, input int ofs);
    bus.in = DSZ'(smp); bus.in_valid = vld[0]; bus.mode = md[1:0]; bus.phs_ofs = (LSZ+2)'(ofs);
  endtask

  initial begin
    bus.in = '0; bus.in_valid = 0; bus.freq = '0; bus.freq_ld = 0;
    bus.phs_ofs = '0; bus.phs_clr = 0; bus.mode = 2'b00;
    #22;
    chk("rst_out_i", bus.out_i, 0);
    chk("rst_out_q", bus.out_q, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;

    // Zero frequency, constant 1000 down-mixed.
    bus.freq = '0; bus.freq_ld = 1; drive(1000, 1, 0, 0);
    tick(); bus.freq_ld = 0;
    repeat (11) tick();
    chk("const_i", bus.out_i, 1000);

    // Quarter-cycle increment, down-mix then up-mix.
    bus.freq = PSZ'(1 << (PSZ - 2)); bus.freq_ld = 1; drive(8191, 0, 0, 0);
    tick(); bus.freq_ld = 0;
    drive(8191, 1, 0, 0); repeat (8) tick();
    drive(8191, 1, 1, 0); repeat (8) tick();
    drive(8191, 1, 1, 37); repeat (4) tick();

    // Saturation: positive sine peak, -8192 down-mixed.
    bus.phs_clr = 1; bus.freq = '0; bus.freq_ld = 1; drive(0, 0, 0, 0);
    tick(); bus.phs_clr = 0; bus.freq_ld = 0;
    drive(-8192, 1, 0, L); repeat (10) tick();
    drive(0, 0, 0, 0); repeat (2) tick();
    chk("sat_q", bus.out_q, 8191);
    chk("unsat_i", bus.out_i, 6);

    // Sparse valids in NCO test mode.
    bus.freq = PSZ'(3 << (PSZ - LSZ - 2)); bus.freq_ld = 1; drive(0, 0, 3, 0);
    tick(); bus.freq_ld = 0;
    for (int r = 0; r < 3; r++) begin
      drive(0, 1, 3, 0); tick();
      drive(0, 0, 3, 0); tick(); tick();
    end
    drive(0, 1, 3, 0); repeat (2) tick();

    // Clear with valid at acc = 0x2000000, plus a same-cycle frequency load.
    bus.phs_clr = 1; bus.freq = PSZ'(26'h2000000); bus.freq_ld = 1; drive(5000, 0, 1, 0);
    tick(); bus.phs_clr = 0; bus.freq_ld = 0;
    drive(5000, 1, 1, 0); tick();
    bus.phs_clr = 1; bus.freq = PSZ'(26'h0100000); bus.freq_ld = 1; drive(5000, 1, 1, 0);
    tick(); bus.phs_clr = 0; bus.freq_ld = 0;
    drive(5000, 1, 1, 0); repeat (3) tick();
    drive(0, 0, 0, 0); repeat (8) tick();
    chk("drain", sb.size(), 0);

    // Reset mid-stream with samples in flight.
    drive(3000, 1, 0, 0); repeat (10) tick();
    @(posedge clk); #3;
    rst_n = 1'b0; drive(0, 0, 0, 0);
    #1;
    chk("mid_rst_i", bus.out_i, 0);
    chk("mid_rst_q", bus.out_q, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (9) tick();
    drive(-5, 1, 2, 0); tick();
    drive(0, 0, 0, 0); repeat (7) tick();
    chk("byp_i", bus.out_i, -5);
    chk("byp_q", bus.out_q, 0);
    chk("byp_valid", bus.out_valid, 1);
    tick();
    chk("byp_hold_i", bus.out_i, -5);
    chk("final_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
